spike_aer_encoder: RTL and testbench

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

---
 rtl/spike_aer_encoder_pkg.sv | 21 ++
 rtl/aer_event_fifo.sv | 55 +++++
 rtl/spike_aer_encoder.sv | 188 ++++++++++++++++++
 tb/tb_spike_aer_encoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_aer_encoder_pkg.sv
// Shared types and widths for the spike AER encoder.
// Optional feature macro: AER_TIMESTAMP_EN (adds an 8-bit event timestamp).
package spike_aer_encoder_pkg;

    localparam int unsigned DROP_CNT_W = 8;
    localparam int unsigned TS_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } aer_state_e;

    // Address width for a given source count; at least one bit.
    function automatic int unsigned addr_width(input int unsigned n_src);
        return (n_src > 1) ? $clog2(n_src) : 1;
    endfunction

    localparam int unsigned AER_ADDR_W = addr_width(8);

endpackage

// File: rtl/aer_event_fifo.sv
// Event queue: show-ahead FIFO with full/empty flags.
// Simultaneous write and read is accepted at any occupancy, including full.
module aer_event_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: pending latch, round-robin arbiter, event FIFO and
// four-phase handshake FSM. Optional macro AER_TIMESTAMP_EN adds aer_ts.
module spike_aer_encoder
    import spike_aer_encoder_pkg::*;
#(
    parameter  int unsigned N_SRC      = 8,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned AW         = addr_width(N_SRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_SRC-1:0]      spike,
    output logic                  aer_req,
    output logic [AW-1:0]         aer_addr,
    input  logic                  aer_ack,
    output logic                  fifo_full,
    output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef AER_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]       aer_ts
`endif
);

`ifdef AER_TIMESTAMP_EN
    localparam int unsigned FW = AW + TS_W;
`else
    localparam int unsigned FW = AW;
`endif
    localparam logic [31:0] DROP_MAX = (32'd1 << DROP_CNT_W) - 32'd1;

    logic [N_SRC-1:0]      pending;
    logic [N_SRC-1:0]      grant;
    logic [N_SRC-1:0]      merged;
    logic [AW-1:0]         rr_ptr;
    logic [AW-1:0]         grant_idx;
    logic                  grant_vld;
    logic [31:0]           drop_sum;
    logic [DROP_CNT_W-1:0] drop_nxt;
    logic [FW-1:0]         fifo_wdata;
    logic [FW-1:0]         fifo_head;
    logic                  fifo_empty;
    logic                  fifo_rd;
    logic                  ack_meta;
    logic                  ack_s;
    aer_state_e            state;
    aer_state_e            state_nxt;
    logic                  req_nxt;
    logic [AW-1:0]         addr_nxt;

    // Round-robin search over pending sources starting at rr_ptr; stalls when full.
    always_comb begin
        logic [31:0]   idx;
        logic [AW-1:0] idx_a;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        idx_a     = '0;
        if (!fifo_full) begin
            for (int unsigned k = 0; k < N_SRC; k++) begin
                idx   = (32'(rr_ptr) + k) % N_SRC;
                idx_a = AW'(idx);
                if (!grant_vld && pending[idx_a]) begin
                    grant[idx_a] = 1'b1;
                    grant_idx    = idx_a;
                    grant_vld    = 1'b1;
                end
            end
        end
    end

    // A spike on a source still pending after this edge's grant is a merge/drop.
    assign merged = spike & pending & ~grant;

    // Saturating drop accumulation, one per merged source per edge.
    always_comb begin
        drop_sum = 32'(drop_cnt) + 32'($countones(merged));
        drop_nxt = (drop_sum > DROP_MAX) ? '1 : DROP_CNT_W'(drop_sum);
    end

    // Pending bits, arbiter pointer and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            pending  <= (pending & ~grant) | spike;
            drop_cnt <= drop_nxt;
            if (grant_vld)
                rr_ptr <= (grant_idx == AW'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_nxt;

    // Free-running timestamp, captured into the FIFO with each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + 1'b1;
    end

    assign fifo_wdata = {ts_cnt, grant_idx};
`else
    assign fifo_wdata = grant_idx;
`endif

    aer_event_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (grant_vld),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Two-flop synchroniser for the asynchronous acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= aer_ack;
            ack_s    <= ack_meta;
        end
    end

    // Handshake next-state and registered-output values.
    always_comb begin
        state_nxt = state;
        req_nxt   = aer_req;
        addr_nxt  = aer_addr;
        fifo_rd   = 1'b0;
`ifdef AER_TIMESTAMP_EN
        ts_nxt    = aer_ts;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd   = 1'b1;
                    req_nxt   = 1'b1;
                    addr_nxt  = fifo_head[AW-1:0];
`ifdef AER_TIMESTAMP_EN
                    ts_nxt    = fifo_head[FW-1:AW];
`endif
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_REL;
                end
            end
            ST_REL: begin
                if (!ack_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            aer_req  <= 1'b0;
            aer_addr <= '0;
`ifdef AER_TIMESTAMP_EN
            aer_ts   <= '0;
`endif
        end else begin
            state    <= state_nxt;
            aer_req  <= req_nxt;
            aer_addr <= addr_nxt;
`ifdef AER_TIMESTAMP_EN
            aer_ts   <= ts_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder; timestamp checks need AER_TIMESTAMP_EN.
`timescale 1ns/1ps
module tb_spike_aer_encoder;

    localparam int unsigned N_SRC      = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] spike   = '0;
    logic       aer_req;
    logic [2:0] aer_addr;
    logic       aer_ack;
    logic       fifo_full;
    logic [7:0] drop_cnt;
`ifdef AER_TIMESTAMP_EN
    logic [7:0] aer_ts;
`endif

    logic       echo_en = 1'b0;
    logic       ack_d1  = 1'b0;
    logic       ack_d2  = 1'b0;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [2:0]  ev_addr[$];
    logic [7:0]  ev_ts[$];
    logic        req_prev    = 1'b0;
    int unsigned full_cycles = 0;

    always #5 clk = ~clk;

    spike_aer_encoder #(
        .N_SRC      (N_SRC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spike     (spike),
        .aer_req   (aer_req),
        .aer_addr  (aer_addr),
        .aer_ack   (aer_ack),
        .fifo_full (fifo_full),
        .drop_cnt  (drop_cnt)
`ifdef AER_TIMESTAMP_EN
        ,
        .aer_ts    (aer_ts)
`endif
    );

    // Receiver: acknowledge echoes request two cycles later when enabled.
    always @(posedge clk) begin
        ack_d1 <= echo_en & aer_req;
        ack_d2 <= ack_d1;
    end
    assign aer_ack = ack_d2;

    // Event monitor: log each request rising edge; count full cycles.
    always @(negedge clk) begin
        if (aer_req && !req_prev) begin
            ev_addr.push_back(aer_addr);
`ifdef AER_TIMESTAMP_EN
            ev_ts.push_back(aer_ts);
`endif
        end
        req_prev = aer_req;
        if (fifo_full) full_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_at(input int unsigned i);
        return (ev_addr.size() > i) ? 32'(ev_addr[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ts_at(input int unsigned i);
        return (ev_ts.size() > i) ? 32'(ev_ts[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        echo_en = 1'b0;
        spike   = '0;
        rst_n   = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Wait for n new events (bounded), then idle to catch duplicates.
    task automatic wait_events(input int unsigned base, input int unsigned n,
                               input int unsigned budget, input string tag);
        int unsigned c = 0;
        while ((ev_addr.size() - base) < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (40) @(negedge clk);
        chk(tag, 32'(ev_addr.size() - base), 32'(n));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned f0;

        // Reset state, then single spike on source 2 on the first edge after release.
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(aer_req), 0);
        chk("rst_addr", 32'(aer_addr), 0);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        base    = ev_addr.size();
        rst_n   = 1'b1;
        spike   = 8'h04;
        echo_en = 1'b1;
        @(negedge clk);
        spike = '0;
        chk("lat_e0_req", 32'(aer_req), 0);
        @(negedge clk);
        chk("lat_e1_req", 32'(aer_req), 0);
        @(negedge clk);
        chk("lat_e2_req", 32'(aer_req), 1);
        chk("lat_e2_addr", 32'(aer_addr), 2);
        wait_events(base, 1, 200, "single_count");
        chk("single_addr", addr_at(base), 2);
        chk("single_drop", 32'(drop_cnt), 0);

        // All sources at once: round-robin order from 0, FIFO fills, no drops.
        apply_reset();
        base    = ev_addr.size();
        f0      = full_cycles;
        rst_n   = 1'b1;
        spike   = 8'hFF;
        echo_en = 1'b1;
        @(negedge clk);
        spike = '0;
        wait_events(base, 8, 1000, "burst_count");
        for (int unsigned i = 0; i < 8; i++)
            chk($sformatf("burst_addr%0d", i), addr_at(base + i), 32'(i));
        chk("burst_full_seen", 32'(full_cycles > f0), 1);
        chk("burst_drop", 32'(drop_cnt), 0);

        // FIFO full, source 5 pulsed three times: one event, two drops.
        apply_reset();
        base  = ev_addr.size();
        rst_n = 1'b1;
        spike = 8'h1F;
        @(negedge clk);
        spike = '0;
        repeat (10) @(negedge clk);
        chk("merge_full", 32'(fifo_full), 1);
        repeat (3) begin
            spike = 8'h20;
            @(negedge clk);
            spike = '0;
            @(negedge clk);
        end
        chk("merge_drop", 32'(drop_cnt), 2);
        echo_en = 1'b1;
        wait_events(base, 6, 2000, "merge_count");
        chk("merge_last_addr", addr_at(base + 5), 5);
        chk("merge_drop_after", 32'(drop_cnt), 2);

        // Saturation: source 3 pulsed 300 times while FIFO is full.
        apply_reset();
        rst_n = 1'b1;
        spike = 8'hFF;
        @(negedge clk);
        spike = '0;
        repeat (10) @(negedge clk);
        chk("sat_full", 32'(fifo_full), 1);
        spike = 8'h08;
        repeat (100) @(negedge clk);
        chk("sat_drop99", 32'(drop_cnt), 99);
        repeat (200) @(negedge clk);
        spike = '0;
        chk("sat_drop255", 32'(drop_cnt), 255);
        repeat (5) @(negedge clk);
        chk("sat_hold", 32'(drop_cnt), 255);
        chk("sat_still_full", 32'(fifo_full), 1);

        // Reset asserted mid-handshake, then a fresh event from source 0.
        apply_reset();
        rst_n = 1'b1;
        spike = 8'h40;
        @(negedge clk);
        spike = '0;
        repeat (4) @(negedge clk);
        chk("midrst_pre_req", 32'(aer_req), 1);
        chk("midrst_pre_addr", 32'(aer_addr), 6);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(aer_req), 0);
        chk("midrst_addr", 32'(aer_addr), 0);
        chk("midrst_full", 32'(fifo_full), 0);
        @(negedge clk);
        base    = ev_addr.size();
        rst_n   = 1'b1;
        spike   = 8'h01;
        echo_en = 1'b1;
        @(negedge clk);
        spike = '0;
        wait_events(base, 1, 200, "midrst_count");
        chk("midrst_ev_addr", addr_at(base), 0);

`ifdef AER_TIMESTAMP_EN
        // Timestamps: src 1 sampled while counter is 10, src 6 while 12.
        apply_reset();
        base  = ev_addr.size();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        spike = 8'h02;
        @(negedge clk);
        spike = '0;
        @(negedge clk);
        spike = 8'h40;
        @(negedge clk);
        spike   = '0;
        echo_en = 1'b1;
        wait_events(base, 2, 500, "ts_count");
        chk("ts_addr0", addr_at(base), 1);
        chk("ts_val0", ts_at(base), 11);
        chk("ts_addr1", addr_at(base + 1), 6);
        chk("ts_val1", ts_at(base + 1), 13);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
